cpu_ifetch: RTL and testbench
=============================

CPU_IFETCH -- requirements
Module: cpu_ifetch

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, is the instruction word loaded into IF/ID on reset and flush.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  is a synchronous, active-high reset.
REQ-004 Port PC  input  32  is the current PC from CPU_PC.
REQ-005 Port pc_hold  output  1  SHALL freeze CPU_PC when high; it is combinational.
REQ-006 Port stall  input  1  is the decode hazard freeze request.
REQ-007 Port flush  input  1  marks a taken branch, jump or exception redirect in this cycle.
REQ-008 Port imem_req  output  1  is the instruction memory request.
REQ-009 Port imem_addr  output  32  is the fetch address.
REQ-010 Port imem_ready  input  1  means imem_rdata is valid this cycle, completing the request.
REQ-011 Port imem_rdata  input  32  is the fetched instruction word.
REQ-012 Port IF_ID_inst  output  32  is the registered instruction.
REQ-013 Port IF_ID_PC4  output  32  is the registered PC+4 of that instruction.
REQ-014 Port IF_ID_valid  output  1  marks IF_ID_inst as a real (non-bubble) instruction.

Function
REQ-015 The FSM SHALL have three states: FETCH, WAIT and HELD, plus a 1-bit discard flag.
REQ-016 In FETCH: imem_req=1 and imem_addr=PC; PC SHALL be latched into addr_q each FETCH cycle.
REQ-017 In WAIT: imem_req=1 and imem_addr=addr_q, held stable until imem_ready.
REQ-018 In HELD: imem_req=0; the captured word is kept in buf_q.
REQ-019 A load event occurs on (FETCH or WAIT) & imem_ready & ~stall & ~flush & ~discard, or on HELD & ~stall & ~flush.
REQ-020 On a load event, IF/ID SHALL be written next edge: IF_ID_inst = rdata or buf_q, IF_ID_valid=1, IF_ID_PC4 = {A[31], A[30:0]+31'd4} with A = fetch address; the supervisor bit is preserved and the low 31 bits wrap.
REQ-021 pc_hold SHALL equal ~load & ~flush while reset is low, and 1 while reset is high; PC therefore advances exactly once per loaded instruction and once on each flush (redirect).
REQ-022 FETCH transitions: ready & load -> FETCH; ready & stall & ~flush -> HELD (buf_q=rdata, buf address=addr source); ~ready -> WAIT.
REQ-023 WAIT transitions: ~ready -> WAIT; ready & load -> FETCH; ready & stall & ~flush & ~discard -> HELD; ready & discard -> FETCH with data dropped and discard cleared.
REQ-024 HELD transitions: stall & ~flush -> HELD; ~stall -> FETCH with load from buf_q.
REQ-025 While stall=1 and flush=0, IF_ID_inst, IF_ID_PC4 and IF_ID_valid SHALL hold their values.
REQ-026 flush SHALL take priority over stall and ready: next edge IF_ID_inst=NOP_INST, IF_ID_valid=0, IF_ID_PC4 unchanged.
REQ-027 Flush in FETCH with ready: data dropped, stay in FETCH. Flush in FETCH with ~ready, or in WAIT with ~ready: go to or stay in WAIT with discard=1. Flush in WAIT with ready: data dropped, go to FETCH. Flush in HELD: buf_q dropped, go to FETCH.
REQ-028 An outstanding request is never cancelled: imem_req stays high in WAIT until imem_ready, even when discarding.
REQ-029 Best-case throughput is one instruction per cycle (ready in the FETCH cycle); latency is PC in -> IF/ID out = 1 edge after ready.

Reset
REQ-030 On reset: state=FETCH, discard=0, IF_ID_inst=NOP_INST, IF_ID_valid=0, IF_ID_PC4=0, buf_q=0, addr_q=0, imem_req=0, pc_hold=1.
REQ-031 Reset SHALL override any in-flight request; the first request is issued in the first cycle after reset deasserts.

Verification
REQ-032 Zero-wait: reset, PC=0x80000000, imem_ready=1 constant, rdata=0x3C011234 -> one edge later IF_ID_inst=0x3C011234, IF_ID_PC4=0x80000004, valid=1, pc_hold=0 every cycle.
REQ-033 Wait states: ready low for 3 cycles -> imem_addr stable, pc_hold=1 for 3 cycles, then a single load on ready.
REQ-034 Stall during ready: stall=1 for 2 cycles while ready=1 -> HELD, imem_req=0, IF/ID unchanged; on stall=0 the buffered word loads and pc_hold=0 for exactly 1 cycle.
REQ-035 Flush in WAIT: flush pulse while waiting, ready 2 cycles later -> IF_ID_valid=0, IF_ID_inst=NOP_INST, the late word discarded; the next fetch uses the redirected PC.
REQ-036 Wrap: PC=0x7FFFFFFC gives IF_ID_PC4=0x00000000; PC=0xFFFFFFFC gives IF_ID_PC4=0x80000000.
REQ-037 flush+stall simultaneous in HELD -> IF/ID cleared, state FETCH, pc_hold=0; reset asserted mid-WAIT -> all REQ-030 values next edge.

Source files
------------

// File: rtl/cpu_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_ifetch                                             |
// | Description : Instruction fetch stage. Issues memory requests,       |
// |               absorbs wait states and decode stalls, handles         |
// |               redirect flushes and drives the IF/ID register.        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module cpu_ifetch #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic        pc_hold,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        discard;
  logic        discard_n;
  logic [31:0] addr_q;
  logic [31:0] buf_q;
  logic [31:0] buf_addr_q;

  logic        load;
  logic        capture;
  logic [31:0] src_addr;
  logic [31:0] src_data;

  // State register: FSM state and the drop-the-late-word flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      discard <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
    end
  end

  // Next-state decode, memory request outputs and load/capture strobes.
  always_comb begin
    state_n   = state;
    discard_n = discard;
    load      = 1'b0;
    capture   = 1'b0;
    imem_req  = 1'b0;
    imem_addr = addr_q;
    src_addr  = addr_q;
    src_data  = imem_rdata;
    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = PC;
        src_addr  = PC;
        if (imem_ready) begin
          if (!flush && !stall) begin
            load = 1'b1;
          end else if (!flush) begin
            capture = 1'b1;
            state_n = S_HELD;
          end
        end else begin
          state_n   = S_WAIT;
          discard_n = flush;
        end
      end
      S_WAIT: begin
        // The outstanding request stays up until memory answers, even when
        // its data is already known to be stale.
        imem_req  = 1'b1;
        imem_addr = addr_q;
        src_addr  = addr_q;
        if (imem_ready) begin
          if (flush || discard) begin
            state_n   = S_FETCH;
            discard_n = 1'b0;
          end else if (stall) begin
            capture = 1'b1;
            state_n = S_HELD;
          end else begin
            load    = 1'b1;
            state_n = S_FETCH;
          end
        end else begin
          discard_n = discard | flush;
        end
      end
      S_HELD: begin
        src_addr = buf_addr_q;
        src_data = buf_q;
        if (flush) begin
          state_n = S_FETCH;
        end else if (!stall) begin
          load    = 1'b1;
          state_n = S_FETCH;
        end
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
      load     = 1'b0;
    end
    // PC moves once per delivered instruction and once per redirect.
    pc_hold = reset | (~load & ~flush);
  end

  // Datapath: fetch address latch, stall buffer and the IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 32'd0;
      buf_q       <= 32'd0;
      buf_addr_q  <= 32'd0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_PC4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        addr_q <= PC;
      end
      if (capture) begin
        buf_q      <= imem_rdata;
        buf_addr_q <= src_addr;
      end
      if (flush) begin
        IF_ID_inst  <= NOP_INST;
        IF_ID_valid <= 1'b0;
      end else if (load) begin
        IF_ID_inst  <= src_data;
        // Supervisor bit is kept; only the low 31 bits increment and wrap.
        IF_ID_PC4   <= {src_addr[31], src_addr[30:0] + 31'd4};
        IF_ID_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ifetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cpu_ifetch                                          |
// | Description : Directed bench for cpu_ifetch with a transaction-level |
// |               reference model and per-cycle output comparison.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_cpu_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_hold;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;

  int total = 0;
  int bad   = 0;

  cpu_ifetch #(.NOP_INST(NOP)) dut (
    .clk        (clk),
    .reset      (rst),
    .PC         (pc),
    .pc_hold    (pc_hold),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (ready),
    .imem_rdata (rdata),
    .IF_ID_inst (if_inst),
    .IF_ID_PC4  (if_pc4),
    .IF_ID_valid(if_valid)
  );

  always #5 clk = ~clk;

  // Reference model state: what decode should see, plus the fetch
  // transaction bookkeeping (a parked word, an open request, a kill mark).
  logic        mvalid = 1'b0;
  logic [31:0] m_inst, m_pc4;
  logic        m_valid;
  logic        held_valid;
  logic [31:0] held_word, held_addr;
  logic        req_open;
  logic [31:0] req_addr;
  logic        kill;

  function automatic logic [31:0] next_pc4(input logic [31:0] a);
    return (a & 32'h8000_0000) | (((a & 32'h7FFF_FFFF) + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge.
  logic        p_req, p_got, p_load;
  logic [31:0] p_addr, p_a;
  always @(posedge clk) begin
    if (rst) begin
      m_inst = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
      held_valid = 1'b0; held_word = 32'd0; held_addr = 32'd0;
      req_open = 1'b0; req_addr = 32'd0; kill = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      p_req  = !held_valid;
      p_addr = req_open ? req_addr : pc;
      p_got  = p_req && ready;
      p_load = !stall && !flush && (held_valid || (p_got && !kill));
      if (flush) begin
        m_inst = NOP; m_valid = 1'b0;
      end else if (p_load) begin
        m_inst  = held_valid ? held_word : rdata;
        p_a     = held_valid ? held_addr : p_addr;
        m_pc4   = next_pc4(p_a);
        m_valid = 1'b1;
      end
      if (held_valid) begin
        held_valid = stall && !flush;
      end else if (p_got && stall && !flush && !kill) begin
        held_valid = 1'b1; held_word = rdata; held_addr = p_addr;
      end
      if (p_req) begin
        if (ready) begin
          req_open = 1'b0; kill = 1'b0;
        end else begin
          if (!req_open) req_addr = p_addr;
          req_open = 1'b1;
          kill = kill | flush;
        end
      end
    end
  end

  // Compare every output against the model in mid-cycle.
  logic        n_req, n_load, n_hold;
  logic [31:0] n_addr;
  always @(negedge clk) begin
    if (mvalid) begin
      n_req  = !rst && !held_valid;
      n_addr = req_open ? req_addr : pc;
      n_load = !rst && !stall && !flush && (held_valid || (n_req && ready && !kill));
      n_hold = rst || (!n_load && !flush);
      chk("pc_hold", {31'd0, pc_hold}, {31'd0, n_hold});
      chk("imem_req", {31'd0, imem_req}, {31'd0, n_req});
      if (n_req) chk("imem_addr", imem_addr, n_addr);
      chk("IF_ID_inst", if_inst, m_inst);
      chk("IF_ID_PC4", if_pc4, m_pc4);
      chk("IF_ID_valid", {31'd0, if_valid}, {31'd0, m_valid});
    end
  end

  task automatic cyc(input logic [31:0] p, input logic r, input logic [31:0] d,
                     input logic s, input logic f);
    pc = p; ready = r; rdata = d; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] i, input logic [31:0] p4,
                     input logic v);
    chk({name, ".inst"}, if_inst, i);
    chk({name, ".pc4"}, if_pc4, p4);
    chk({name, ".valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1;
    cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    lit("reset", NOP, 32'h0, 1'b0);
    rst = 1'b0;

    // Zero-wait streaming
    cyc(32'h8000_0000, 1'b1, 32'h3C01_1234, 1'b0, 1'b0);
    lit("zw0", 32'h3C01_1234, 32'h8000_0004, 1'b1);
    cyc(32'h8000_0004, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    cyc(32'h8000_0008, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    lit("zw2", 32'h2222_2222, 32'h8000_000C, 1'b1);

    // Three wait states; PC input wiggles to prove the address is latched
    cyc(32'h8000_000C, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("wait_hold", 32'h2222_2222, 32'h8000_000C, 1'b1);
    cyc(32'h8000_000C, 1'b1, 32'h3333_3333, 1'b0, 1'b0);
    lit("wait_done", 32'h3333_3333, 32'h8000_0010, 1'b1);

    // Stall while ready: word parked, IF/ID frozen, then released
    cyc(32'h8000_0010, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
    cyc(32'h8000_0010, 1'b1, 32'h5555_5555, 1'b1, 1'b0);
    lit("stall", 32'h3333_3333, 32'h8000_0010, 1'b1);
    cyc(32'h8000_0010, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("unstall", 32'h4444_4444, 32'h8000_0014, 1'b1);

    // Flush while waiting; the late word must be dropped
    cyc(32'h8000_0014, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h8000_0014, 1'b0, 32'h0, 1'b0, 1'b1);
    lit("flush_wait", NOP, 32'h8000_0014, 1'b0);
    cyc(32'h0040_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h0040_0000, 1'b1, 32'h6666_6666, 1'b0, 1'b0);
    lit("discarded", NOP, 32'h8000_0014, 1'b0);
    cyc(32'h0040_0000, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    lit("redirect", 32'h7777_7777, 32'h0040_0004, 1'b1);

    // Flush in FETCH without ready, then with ready
    cyc(32'h0040_0004, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(32'h0050_0000, 1'b1, 32'h0000_0088, 1'b0, 1'b0);
    cyc(32'h0050_0000, 1'b1, 32'h0000_0099, 1'b0, 1'b1);
    lit("flush_fetch", NOP, 32'h0040_0004, 1'b0);

    // Low-31-bit wrap with the top bit preserved
    cyc(32'h7FFF_FFFC, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0);
    lit("wrap0", 32'h0000_AAAA, 32'h0000_0000, 1'b1);
    cyc(32'hFFFF_FFFC, 1'b1, 32'h0000_BBBB, 1'b0, 1'b0);
    lit("wrap1", 32'h0000_BBBB, 32'h8000_0000, 1'b1);

    // flush and stall together while a word is parked
    cyc(32'h0000_1000, 1'b1, 32'h0000_00CC, 1'b1, 1'b0);
    cyc(32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b1);
    lit("held_flush", NOP, 32'h8000_0000, 1'b0);
    cyc(32'h0000_2000, 1'b1, 32'h0000_00DD, 1'b0, 1'b0);
    lit("after_held", 32'h0000_00DD, 32'h0000_2004, 1'b1);

    // Stall during a wait, data arrives while still stalled
    cyc(32'h0000_2004, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(32'h0000_2004, 1'b1, 32'h0000_00EE, 1'b1, 1'b0);
    cyc(32'h0000_2004, 1'b0, 32'h0, 1'b0, 1'b0);
    lit("wait_stall", 32'h0000_00EE, 32'h0000_2008, 1'b1);

    // Reset in the middle of a wait
    cyc(32'h0000_3000, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(32'h0000_3000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    lit("mid_reset", NOP, 32'h0, 1'b0);
    rst = 1'b0;
    cyc(32'h0000_4000, 1'b1, 32'h0000_0012, 1'b0, 1'b0);
    lit("post_reset", 32'h0000_0012, 32'h0000_4004, 1'b1);
    cyc(32'h0000_4004, 1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
